ram_arbiter: RTL and testbench

- Shares the single-port data RAM between two bus masters: m0 (CPU data path via the MIO bus) and m1 (debug/program-loader port).
- Sits between the MIO bus RAM-side signals and the RAM macro. It replaces the direct bus-to-RAM connection.
- Round-robin arbitration with a request/grant handshake. Issues one RAM access at a time and returns read data with a valid pulse to the winning master.

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/ram_arbiter_rr_arb2.sv | 42 ++++
 rtl/ram_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM arbiter: FSM encoding, master indices,
// default read latency and a small index-to-one-hot helper.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_e;

   localparam logic MASTER_CPU     = 1'b0;
   localparam logic MASTER_DBG     = 1'b1;
   localparam int   RD_LAT_DEFAULT = 1;

   function automatic logic [1:0] master_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the
// master that was not granted last. Purely combinational.
module rr_arb2
   import ram_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       enable,
   output logic [1:0] grant,
   output logic       winner
);

   // Winner selection, gated by enable so grants only form in IDLE.
   always_comb begin
      grant  = 2'b00;
      winner = MASTER_CPU;
      if (enable) begin
         case (req)
            2'b01: begin
               winner = MASTER_CPU;
               grant  = master_onehot(MASTER_CPU);
            end
            2'b10: begin
               winner = MASTER_DBG;
               grant  = master_onehot(MASTER_DBG);
            end
            2'b11: begin
               winner = ~last_grant;
               grant  = master_onehot(~last_grant);
            end
            default: begin
               winner = MASTER_CPU;
               grant  = 2'b00;
            end
         endcase
      end else begin
         grant  = 2'b00;
         winner = MASTER_CPU;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between the CPU data path (m0) and the debug
// loader (m1): one access at a time, round-robin, read data with rvalid.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int RD_LAT = RD_LAT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

   state_e            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              last_q, last_d;
   logic              owner_q, owner_d;
   logic              is_rd_q, is_rd_d;
   logic [1:0]        gnt_q, gnt_d;
   logic [1:0]        rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              ram_we_q, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_din_q, ram_din_d;

   logic [1:0]        arb_grant;
   logic              arb_winner;
   logic              capture;

   rr_arb2 u_rr_arb2 (
      .req        ({m1_req, m0_req}),
      .last_grant (last_q),
      .enable     (state_q == IDLE),
      .grant      (arb_grant),
      .winner     (arb_winner)
   );

   // Next-state, access launch and read-capture decisions.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      owner_d    = owner_q;
      is_rd_d    = is_rd_q;
      gnt_d      = 2'b00;
      rvalid_d   = 2'b00;
      rdata_d    = rdata_q;
      ram_we_d   = 1'b0;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      capture    = 1'b0;

      case (state_q)
         IDLE: begin
            if (arb_grant != 2'b00) begin
               ram_addr_d = arb_winner ? m1_addr  : m0_addr;
               ram_din_d  = arb_winner ? m1_wdata : m0_wdata;
               ram_we_d   = arb_winner ? m1_we    : m0_we;
               is_rd_d    = arb_winner ? ~m1_we   : ~m0_we;
               gnt_d      = arb_grant;
               last_d     = arb_winner;
               owner_d    = arb_winner;
               state_d    = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (!is_rd_q) begin
               state_d = IDLE;
            end else if (RD_LAT == 1) begin
               capture = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d   = CNT_INIT;
               state_d = WAIT;
            end
         end
         WAIT: begin
            // cnt reaching 1 marks the edge where ram_dout is valid.
            if (cnt_q <= 3'd1) begin
               capture = 1'b1;
               cnt_d   = 3'd0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (capture) begin
         rdata_d  = ram_dout;
         rvalid_d = master_onehot(owner_q);
      end else begin
         rdata_d  = rdata_q;
         rvalid_d = 2'b00;
      end
   end

   // State, access and capture registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 3'd0;
         last_q     <= MASTER_DBG;
         owner_q    <= MASTER_CPU;
         is_rd_q    <= 1'b0;
         gnt_q      <= 2'b00;
         rvalid_q   <= 2'b00;
         rdata_q    <= {DATA_W{1'b0}};
         ram_we_q   <= 1'b0;
         ram_addr_q <= {ADDR_W{1'b0}};
         ram_din_q  <= {DATA_W{1'b0}};
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         owner_q    <= owner_d;
         is_rd_q    <= is_rd_d;
         gnt_q      <= gnt_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         ram_we_q   <= ram_we_d;
         ram_addr_q <= ram_addr_d;
         ram_din_q  <= ram_din_d;
      end
   end

   assign m0_gnt    = gnt_q[0];
   assign m1_gnt    = gnt_q[1];
   assign m0_rvalid = rvalid_q[0];
   assign m1_rvalid = rvalid_q[1];
   assign rdata     = rdata_q;
   assign busy      = (state_q != IDLE);
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_din   = ram_din_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: two instances (RD_LAT 1 and 3) share stimulus and are
// checked every cycle against a timeline model of grants, accesses and returns.
module tb_ram_arbiter;

   localparam int AW = 10;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;
   logic preload;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   logic rand_mode;
   logic [1:0] oneshot;

   logic [1:0]    req    [2];
   logic [1:0]    we_in  [2];
   logic [AW-1:0] addr_in[2][2];
   logic [DW-1:0] wd_in  [2][2];
   logic [1:0]    gnt    [2];
   logic [1:0]    rv     [2];
   logic [DW-1:0] rdata  [2];
   logic          busy   [2];
   logic          ram_we [2];
   logic [AW-1:0] ram_addr[2];
   logic [DW-1:0] ram_din [2];
   logic [DW-1:0] ram_dout[2];

   // RAM models and reference model state
   logic [DW-1:0] mem   [2][1024];
   logic [AW-1:0] ap    [2][2];
   logic [DW-1:0] shadow[2][1024];
   int            free_t[2];
   logic          last  [2];
   logic          acc_v [2];
   int            acc_t [2];
   logic          acc_m [2];
   logic          acc_we[2];
   logic [AW-1:0] acc_addr[2];
   logic [DW-1:0] acc_data[2];
   logic          rv_v  [2];
   int            rv_t  [2];
   logic          rv_m  [2];
   logic [DW-1:0] rv_d  [2];
   logic [DW-1:0] exp_rdata[2];

   ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut0 (
      .clk(clk), .rst(rst),
      .m0_req(req[0][0]), .m0_we(we_in[0][0]), .m0_addr(addr_in[0][0]), .m0_wdata(wd_in[0][0]),
      .m0_gnt(gnt[0][0]), .m0_rvalid(rv[0][0]),
      .m1_req(req[0][1]), .m1_we(we_in[0][1]), .m1_addr(addr_in[0][1]), .m1_wdata(wd_in[0][1]),
      .m1_gnt(gnt[0][1]), .m1_rvalid(rv[0][1]),
      .rdata(rdata[0]), .busy(busy[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]),
      .ram_din(ram_din[0]), .ram_dout(ram_dout[0])
   );

   ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_dut1 (
      .clk(clk), .rst(rst),
      .m0_req(req[1][0]), .m0_we(we_in[1][0]), .m0_addr(addr_in[1][0]), .m0_wdata(wd_in[1][0]),
      .m0_gnt(gnt[1][0]), .m0_rvalid(rv[1][0]),
      .m1_req(req[1][1]), .m1_we(we_in[1][1]), .m1_addr(addr_in[1][1]), .m1_wdata(wd_in[1][1]),
      .m1_gnt(gnt[1][1]), .m1_rvalid(rv[1][1]),
      .rdata(rdata[1]), .busy(busy[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]),
      .ram_din(ram_din[1]), .ram_dout(ram_dout[1])
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] init_val(input int i);
      if (i == 5) return 32'hDEADBEEF;
      return 32'hC0DE0000 ^ (32'(i) << 8) ^ 32'(i);
   endfunction

   function automatic int rl(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   // RAM 0 reads combinationally; RAM 1 delays the address two stages.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (preload) begin
            for (int i = 0; i < 1024; i++) mem[d][i] <= init_val(i);
         end else if (ram_we[d] === 1'b1) begin
            mem[d][ram_addr[d]] <= ram_din[d];
         end
         ap[d][0] <= ram_addr[d];
         ap[d][1] <= ap[d][0];
      end
   end

   assign ram_dout[0] = mem[0][ram_addr[0]];
   assign ram_dout[1] = mem[1][ap[1][1]];

   task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, d, cyc, obs, exp);
      end
   endtask

   task automatic model_reset(input int d);
      free_t[d]    = 0;
      last[d]      = 1'b1;
      acc_v[d]     = 1'b0;
      acc_t[d]     = -1;
      acc_m[d]     = 1'b0;
      acc_we[d]    = 1'b0;
      acc_addr[d]  = '0;
      acc_data[d]  = '0;
      rv_v[d]      = 1'b0;
      rv_t[d]      = -1;
      rv_m[d]      = 1'b0;
      rv_d[d]      = '0;
      exp_rdata[d] = '0;
   endtask

   task automatic check_reset(input int d);
      chk("rst_gnt",   d, 64'(gnt[d]),      64'd0);
      chk("rst_rv",    d, 64'(rv[d]),       64'd0);
      chk("rst_rdata", d, 64'(rdata[d]),    64'd0);
      chk("rst_busy",  d, 64'(busy[d]),     64'd0);
      chk("rst_we",    d, 64'(ram_we[d]),   64'd0);
      chk("rst_addr",  d, 64'(ram_addr[d]), 64'd0);
      chk("rst_din",   d, 64'(ram_din[d]),  64'd0);
   endtask

   // Arbitration happens only on an edge that ends an idle cycle.
   task automatic decide(input int d);
      logic w;
      if (cyc >= free_t[d] && req[d] != 2'b00) begin
         w = (req[d] == 2'b11) ? ~last[d] : req[d][1];
         acc_v[d]    = 1'b1;
         acc_t[d]    = cyc + 1;
         acc_m[d]    = w;
         acc_we[d]   = we_in[d][w];
         acc_addr[d] = addr_in[d][w];
         acc_data[d] = wd_in[d][w];
         last[d]     = w;
         if (we_in[d][w]) begin
            shadow[d][addr_in[d][w]] = wd_in[d][w];
            free_t[d] = cyc + 2;
         end else begin
            free_t[d] = cyc + 1 + rl(d);
            rv_v[d]   = 1'b1;
            rv_t[d]   = cyc + 1 + rl(d);
            rv_m[d]   = w;
            rv_d[d]   = shadow[d][addr_in[d][w]];
         end
      end
   endtask

   task automatic check(input int d);
      logic       issue_now, rv_now;
      logic [1:0] eg, er;
      issue_now = acc_v[d] && (acc_t[d] == cyc);
      eg = issue_now ? (acc_m[d] ? 2'b10 : 2'b01) : 2'b00;
      rv_now = rv_v[d] && (rv_t[d] == cyc);
      er = rv_now ? (rv_m[d] ? 2'b10 : 2'b01) : 2'b00;
      if (rv_now) exp_rdata[d] = rv_d[d];
      chk("gnt",      d, 64'(gnt[d]),      64'(eg));
      chk("rvalid",   d, 64'(rv[d]),       64'(er));
      chk("rdata",    d, 64'(rdata[d]),    64'(exp_rdata[d]));
      chk("busy",     d, 64'(busy[d]),     64'(cyc < free_t[d]));
      chk("ram_we",   d, 64'(ram_we[d]),   64'(issue_now && acc_we[d]));
      chk("ram_addr", d, 64'(ram_addr[d]), 64'(acc_addr[d]));
      chk("ram_din",  d, 64'(ram_din[d]),  64'(acc_data[d]));
   endtask

   task automatic new_req(input int d, input int m);
      req[d][m]     = 1'b1;
      we_in[d][m]   = 1'($urandom_range(0, 1));
      addr_in[d][m] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15))
                                                  : AW'($urandom_range(0, 1023));
      wd_in[d][m]   = $urandom;
   endtask

   task automatic tick();
      for (int d = 0; d < 2; d++) decide(d);
      @(negedge clk);
      for (int d = 0; d < 2; d++) check(d);
      for (int d = 0; d < 2; d++) begin
         for (int m = 0; m < 2; m++) begin
            if (acc_v[d] && acc_t[d] == cyc && acc_m[d] == 1'(m) && (rand_mode || oneshot[m]))
               req[d][m] = 1'b0;
            if (rand_mode && !req[d][m] && $urandom_range(0, 99) < 45)
               new_req(d, m);
         end
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic setm(input int m, input logic r, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] dat);
      for (int d = 0; d < 2; d++) begin
         req[d][m]     = r;
         we_in[d][m]   = we;
         addr_in[d][m] = a;
         wd_in[d][m]   = dat;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int d = 0; d < 2; d++) req[d] = 2'b00;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         model_reset(d);
         check_reset(d);
      end
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      preload   = 1'b1;
      rand_mode = 1'b0;
      oneshot   = 2'b11;
      setm(0, 1'b0, 1'b0, '0, '0);
      setm(1, 1'b0, 1'b0, '0, '0);
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 1024; i++) shadow[d][i] = init_val(i);
      @(negedge clk);
      @(negedge clk);
      preload = 1'b0;
      do_reset();

      // m0 read of the preloaded word at 0x005
      setm(0, 1'b1, 1'b0, 10'h005, 32'h0);
      ticks(6);
      chk("first_read_rdata", 0, 64'(rdata[0]), 64'h00000000DEADBEEF);
      chk("first_read_rdata", 1, 64'(rdata[1]), 64'h00000000DEADBEEF);

      // m1 write to the top address, then m0 reads it back
      setm(1, 1'b1, 1'b1, 10'h3FF, 32'h12345678);
      ticks(4);
      setm(0, 1'b1, 1'b0, 10'h3FF, 32'h0);
      ticks(6);
      chk("readback_rdata", 0, 64'(rdata[0]), 64'h0000000012345678);
      chk("readback_rdata", 1, 64'(rdata[1]), 64'h0000000012345678);

      // both masters hold read requests: grants must alternate
      oneshot = 2'b00;
      setm(0, 1'b1, 1'b0, 10'h001, 32'h0);
      setm(1, 1'b1, 1'b0, 10'h002, 32'h0);
      ticks(16);
      setm(0, 1'b0, 1'b0, 10'h001, 32'h0);
      setm(1, 1'b0, 1'b0, 10'h002, 32'h0);
      oneshot = 2'b11;
      ticks(6);

      // m1 raised while an m0 read is in flight
      setm(0, 1'b1, 1'b0, 10'h007, 32'h0);
      ticks(2);
      setm(1, 1'b1, 1'b0, 10'h008, 32'h0);
      ticks(8);

      // reset in the middle of a read, then a tie must go to m0
      setm(0, 1'b1, 1'b0, 10'h009, 32'h0);
      ticks(2);
      do_reset();
      ticks(4);
      setm(0, 1'b1, 1'b0, 10'h00A, 32'h0);
      setm(1, 1'b1, 1'b0, 10'h00B, 32'h0);
      tick();
      chk("tie_after_reset", 0, 64'(gnt[0]), 64'd1);
      chk("tie_after_reset", 1, 64'(gnt[1]), 64'd1);
      ticks(10);

      // m0 pulse while busy must be ignored
      setm(1, 1'b1, 1'b0, 10'h004, 32'h0);
      tick();
      setm(0, 1'b1, 1'b1, 10'h00C, 32'h55AA55AA);
      tick();
      setm(0, 1'b0, 1'b1, 10'h00C, 32'h55AA55AA);
      ticks(6);

      // randomized traffic
      rand_mode = 1'b1;
      ticks(400);
      rand_mode = 1'b0;
      setm(0, 1'b0, 1'b0, '0, '0);
      setm(1, 1'b0, 1'b0, '0, '0);
      ticks(8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
